// File: rtl/pipe_pkg.sv
// Shared opcodes, FSM encoding and helpers for the pipeline sequencer.
package pipe_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'h5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-flush detection between the DE and EX stages.
module hazard_detect #(
  parameter int REG_INDEX_BIT_WIDTH = 4
) (
  input  logic [REG_INDEX_BIT_WIDTH-1:0] de_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] de_rs2,
  input  logic                           de_use_rs1,
  input  logic                           de_use_rs2,
  input  logic [3:0]                     ex_op,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  input  logic                           ex_wrReg,
  input  logic                           ex_br_taken,
  output logic                           load_use,
  output logic                           br_flush
);
  import pipe_pkg::*;

  logic ex_load_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign ex_load_s = (ex_op == OP_LW) && ex_wrReg &&
                     (ex_rd != {REG_INDEX_BIT_WIDTH{1'b0}});
  assign rs1_hit_s = de_use_rs1 && (de_rs1 == ex_rd);
  assign rs2_hit_s = de_use_rs2 && (de_rs2 == ex_rd);

  assign load_use = ex_load_s && (rs1_hit_s || rs2_hit_s);
  assign br_flush = ex_br_taken;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: memory-wait FSM, hazard priority muxing and stall counter.
module pipe_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int MEM_TIMEOUT         = 64,
  parameter int CNT_BITS            = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           halt,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] de_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] de_rs2,
  input  logic                           de_use_rs1,
  input  logic                           de_use_rs2,
  input  logic [3:0]                     ex_op,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  input  logic                           ex_wrReg,
  input  logic                           ex_br_taken,
  input  logic [3:0]                     mem_op,
  input  logic                           mem_ready,
  output logic                           pc_wrt_en,
  output logic                           fd_wrt_en,
  output logic                           de_wrt_en,
  output logic                           em_wrt_en,
  output logic                           me_wrt_en,
  output logic                           fd_bubble,
  output logic                           de_bubble,
  output logic                           em_bubble,
  output logic                           me_bubble,
  output logic                           mem_req,
  output logic                           mem_err,
  output logic [CNT_BITS-1:0]            stall_cycles
);
  import pipe_pkg::*;

  localparam int              WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WCW-1:0]       wait_cnt_r;
  logic [WCW-1:0]       wait_cnt_nxt_s;
  logic                 mem_err_r;
  logic [CNT_BITS-1:0]  stall_cnt_r;

  logic mem_op_s;
  logic timeout_s;
  logic mem_hold_s;
  logic halt_s;
  logic load_use_s;
  logic br_flush_s;

  logic pc_en_s, fd_en_s, de_en_s, em_en_s, me_en_s;
  logic fd_bub_s, de_bub_s, em_bub_s, me_bub_s;

  hazard_detect #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH)
  ) u_hazard_detect (
    .de_rs1      (de_rs1),
    .de_rs2      (de_rs2),
    .de_use_rs1  (de_use_rs1),
    .de_use_rs2  (de_use_rs2),
    .ex_op       (ex_op),
    .ex_rd       (ex_rd),
    .ex_wrReg    (ex_wrReg),
    .ex_br_taken (ex_br_taken),
    .load_use    (load_use_s),
    .br_flush    (br_flush_s)
  );

  assign mem_op_s   = is_mem_op(mem_op);
  assign timeout_s  = (state_r == MEM_WAIT) && mem_op_s && !mem_ready &&
                      (wait_cnt_r == WAIT_LAST);
  // The memory stage holds the pipe until the access completes or is forced out.
  assign mem_hold_s = mem_op_s && !mem_ready && !timeout_s;
  assign halt_s     = (state_r == RUN) && !mem_op_s && halt;

  // FSM next state and wait counter.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      RUN: begin
        wait_cnt_nxt_s = {WCW{1'b0}};
        if (mem_hold_s) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_hold_s) begin
          wait_cnt_nxt_s = wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WCW{1'b0}};
        end
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = {WCW{1'b0}};
      end
    endcase
  end

  // Hazard priority: memory wait > halt > branch > load-use.
  always_comb begin
    pc_en_s  = 1'b1;
    fd_en_s  = 1'b1;
    de_en_s  = 1'b1;
    em_en_s  = 1'b1;
    me_en_s  = 1'b1;
    fd_bub_s = 1'b0;
    de_bub_s = 1'b0;
    em_bub_s = 1'b0;
    me_bub_s = 1'b0;
    if (mem_hold_s) begin
      pc_en_s  = 1'b0;
      fd_en_s  = 1'b0;
      de_en_s  = 1'b0;
      em_en_s  = 1'b0;
      me_bub_s = 1'b1;
    end else if (halt_s) begin
      pc_en_s = 1'b0;
      fd_en_s = 1'b0;
      de_en_s = 1'b0;
      em_en_s = 1'b0;
      me_en_s = 1'b0;
    end else if (br_flush_s) begin
      fd_bub_s = 1'b1;
      de_bub_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s  = 1'b0;
      fd_en_s  = 1'b0;
      de_en_s  = 1'b0;
      em_bub_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      wait_cnt_r  <= {WCW{1'b0}};
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_BITS{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
      if (!pc_en_s && (stall_cnt_r != {CNT_BITS{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  // Controls are held inactive for as long as reset is asserted.
  assign pc_wrt_en    = reset & pc_en_s;
  assign fd_wrt_en    = reset & fd_en_s;
  assign de_wrt_en    = reset & de_en_s;
  assign em_wrt_en    = reset & em_en_s;
  assign me_wrt_en    = reset & me_en_s;
  assign fd_bubble    = reset & fd_bub_s;
  assign de_bubble    = reset & de_bub_s;
  assign em_bubble    = reset & em_bub_s;
  assign me_bubble    = reset & me_bub_s;
  assign mem_req      = reset & mem_op_s;
  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with a short memory timeout.
module tb_pipe_ctrl;
  localparam int RW = 4;
  localparam int CB = 32;

  localparam logic [3:0] LW = 4'h9;
  localparam logic [3:0] SW = 4'h5;

  // {pc,fd,de,em,me, fd_b,de_b,em_b,me_b, mem_req}
  localparam logic [9:0] V_ZERO = 10'b00000_0000_0;
  localparam logic [9:0] V_RUN  = 10'b11111_0000_0;
  localparam logic [9:0] V_RUNR = 10'b11111_0000_1;
  localparam logic [9:0] V_HALT = 10'b00000_0000_0;
  localparam logic [9:0] V_LU   = 10'b00011_0010_0;
  localparam logic [9:0] V_MW   = 10'b00001_0001_1;
  localparam logic [9:0] V_BR   = 10'b11111_1100_0;
  localparam logic [9:0] V_BRR  = 10'b11111_1100_1;

  logic clk = 1'b0;
  logic reset, halt;
  logic [RW-1:0] de_rs1, de_rs2, ex_rd;
  logic de_use_rs1, de_use_rs2, ex_wrReg, ex_br_taken, mem_ready;
  logic [3:0] ex_op, mem_op;
  logic pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, me_wrt_en;
  logic fd_bubble, de_bubble, em_bubble, me_bubble, mem_req, mem_err;
  logic [CB-1:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_stall = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_INDEX_BIT_WIDTH(RW), .MEM_TIMEOUT(4), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_wrReg(ex_wrReg), .ex_br_taken(ex_br_taken),
    .mem_op(mem_op), .mem_ready(mem_ready),
    .pc_wrt_en(pc_wrt_en), .fd_wrt_en(fd_wrt_en), .de_wrt_en(de_wrt_en),
    .em_wrt_en(em_wrt_en), .me_wrt_en(me_wrt_en),
    .fd_bubble(fd_bubble), .de_bubble(de_bubble), .em_bubble(em_bubble), .me_bubble(me_bubble),
    .mem_req(mem_req), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  wire [9:0] dut_vec = {pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, me_wrt_en,
                        fd_bubble, de_bubble, em_bubble, me_bubble, mem_req};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Push the expectation, compare after settling, then advance one clock.
  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    sb_q.push_back(exp);
    #1;
    e = sb_q.pop_front();
    check(tag, {22'd0, dut_vec}, {22'd0, e});
    check({tag, "_stall"}, stall_cycles, exp_stall);
    if (e[9] == 1'b0) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 1'b0; de_rs1 = 4'd0; de_rs2 = 4'd0; de_use_rs1 = 1'b0; de_use_rs2 = 1'b0;
    ex_op = 4'h0; ex_rd = 4'd0; ex_wrReg = 1'b0; ex_br_taken = 1'b0;
    mem_op = 4'h0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    mem_op = LW;
    #1;
    check("reset_vec", {22'd0, dut_vec}, 32'd0);
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk); #1;
    mem_op = 4'h0;
    reset = 1'b1;

    step("idle", V_RUN);
    halt = 1'b1;
    step("halt", V_HALT);
    halt = 1'b0;

    // Load-use on rs1, then the r0 exemption and other non-hazards.
    ex_op = LW; ex_wrReg = 1'b1; ex_rd = 4'd3; de_rs1 = 4'd3; de_use_rs1 = 1'b1;
    step("lu_rs1", V_LU);
    ex_rd = 4'd0; de_rs1 = 4'd0;
    step("lu_r0", V_RUN);
    ex_rd = 4'd5; de_rs2 = 4'd5; de_use_rs2 = 1'b1; de_use_rs1 = 1'b0;
    step("lu_rs2", V_LU);
    de_use_rs2 = 1'b0;
    step("lu_unused", V_RUN);
    de_use_rs2 = 1'b1; ex_wrReg = 1'b0;
    step("lu_nowr", V_RUN);
    ex_wrReg = 1'b1; ex_op = SW;
    step("lu_sw", V_RUN);
    ex_op = LW; ex_br_taken = 1'b1;
    step("br_lu", V_BR);
    idle_inputs();

    // Two-wait load: stall twice, then release.
    mem_op = LW;
    step("mw_1", V_MW);
    step("mw_2", V_MW);
    mem_ready = 1'b1;
    step("mw_rel", V_RUNR);
    check("mw_stall_total", stall_cycles, 32'd5);
    mem_op = SW;
    step("zero_wait", V_RUNR);
    mem_op = 4'h0; mem_ready = 1'b0;
    step("after_zw", V_RUN);

    // Branch held in EX during a store wait.
    mem_op = SW; ex_br_taken = 1'b1;
    step("brw_1", V_MW);
    step("brw_2", V_MW);
    mem_ready = 1'b1;
    step("brw_rel", V_BRR);
    idle_inputs();

    // Timeout with halt held: halt must not interfere.
    mem_op = LW; halt = 1'b1;
    step("to_1", V_MW);
    step("to_2", V_MW);
    step("to_3", V_MW);
    step("to_4", V_MW);
    check("to_err_pre", {31'd0, mem_err}, 32'd0);
    step("to_rel", V_RUNR);
    check("to_err_set", {31'd0, mem_err}, 32'd1);
    mem_op = 4'h0;
    step("halt_after_to", V_HALT);
    halt = 1'b0;
    step("idle_after_to", V_RUN);
    check("to_err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset pulse in the middle of a wait.
    mem_op = LW;
    step("rw_1", V_MW);
    step("rw_2", V_MW);
    reset = 1'b0;
    #1;
    check("rw_async_vec", {22'd0, dut_vec}, {22'd0, V_ZERO});
    check("rw_async_stall", stall_cycles, 32'd0);
    check("rw_async_err", {31'd0, mem_err}, 32'd0);
    exp_stall = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    step("rw_rereq", V_MW);
    step("rw_wait", V_MW);
    mem_ready = 1'b1;
    step("rw_rel", V_RUNR);
    check("rw_stall_total", stall_cycles, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the 5-stage core (FE → DE → EX → MEM → WB). It generates write-enable and bubble controls for the PC and the FD, DE, EM and ME pipeline registers. It resolves three hazards: load-use stalls, taken-branch flushes, and variable-latency data-memory waits via a req/ready handshake with a timeout. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- REG_INDEX_BIT_WIDTH, 4: register index width.
- MEM_TIMEOUT, 64: maximum wait cycles for a memory access before forced release.
- CNT_BITS, 32: width of the stall counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- halt  in  1  debug freeze; honoured only in RUN.
- de_rs1, de_rs2  in  REG_INDEX_BIT_WIDTH  source indices of the instruction in DE.
- de_use_rs1, de_use_rs2  in  1  the DE instruction reads that source.
- ex_op  in  4  opcode in EX.
- ex_rd  in  REG_INDEX_BIT_WIDTH  destination register in EX.
- ex_wrReg  in  1  the EX instruction writes a register.
- ex_br_taken  in  1  EX redirects the PC (taken branch or jump).
- mem_op  in  4  opcode in MEM (EM register output).
- mem_ready  in  1  data memory completes the current access this cycle.
- pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, me_wrt_en  out  1  pipeline register enables.
- fd_bubble, de_bubble, em_bubble, me_bubble  out  1  the corresponding register loads a NOP (op 0, wrReg 0) on this edge.
- mem_req  out  1  data-memory access request.
- mem_err  out  1  sticky; a timeout occurred.
- stall_cycles  out  CNT_BITS  count of cycles with pc_wrt_en = 0.

## Operation
- Memory ops are mem_op ∈ {OP_LW, OP_SW}. mem_req = 1 whenever a memory op is in MEM, in either state.
- FSM states:
  - RUN → MEM_WAIT when a memory op is in MEM and mem_ready = 0.
  - MEM_WAIT → RUN on mem_ready = 1, or when wait_cnt reaches MEM_TIMEOUT−1. On timeout, set mem_err and release.
- MEM_WAIT, and any RUN cycle with a memory op but no mem_ready:
  - pc/fd/de/em_wrt_en = 0.
  - me_wrt_en = 1 with me_bubble = 1, so WB sees NOPs.
  - All other hazards are deferred.
- Release cycle (mem_ready or timeout): all enables = 1 and me_bubble = 0.
- Load-use hazard: ex_op = OP_LW, ex_wrReg = 1, ex_rd ≠ 0, and ex_rd matches a used DE source.
  - Action: pc/fd/de_wrt_en = 0, em_bubble = 1. Lasts one cycle.
- Branch: ex_br_taken = 1 → fd_bubble = 1 and de_bubble = 1 (flushes two younger instructions); PC loads the target.
- Priority, highest first: memory wait > halt > branch > load-use.
  - Branch and load-use together: branch wins and no stall is taken.
  - A branch held in EX during a memory wait acts on the release cycle.
- halt in RUN with no memory op pending: all enables 0 and no bubbles.
- Default (no hazard): all enables 1, all bubbles 0.
- stall_cycles increments on every cycle with pc_wrt_en = 0 and saturates at all-ones.
- wait_cnt clears on entry to MEM_WAIT and on exit.

## Timing
- Reset low (asynchronous):
  - state = RUN; wait_cnt = 0; mem_err = 0; stall_cycles = 0.
  - All enable, bubble and mem_req outputs are forced to 0 while reset is low.
- Hazard outputs are combinational from the current inputs and state, for use on the same edge. Zero-cycle added latency.
- Zero-wait memory (mem_ready in the first cycle) causes no stall and no MEM_WAIT entry.
- N-wait memory: stalls N cycles; the release occurs in cycle N+1.
- Back-to-back memory ops each produce an independent request. mem_req may stay high across the release edge.
- Reset deasserted mid-wait: the FSM resumes in RUN and a pending mem_op re-requests.

## Structure
- pipe_pkg holds: OP_LW = 4'h9, OP_SW = 4'h5, the state encoding (RUN = 1'b0, MEM_WAIT = 1'b1) and a NOP op constant of 4'h0.
- One combinational sub-module, hazard_detect, computes the load-use match and the branch flush. pipe_ctrl owns the FSM, the counters and the priority muxing.

## Test plan
- Load-use: LW r3 in EX and DE reads r3 → one cycle with pc/fd/de_wrt_en = 0 and em_bubble = 1; stall_cycles += 1. Repeat with ex_rd = 0 → no stall.
- Memory wait: LW in MEM, mem_ready asserted on the 3rd cycle → 2 stall cycles with me_bubble = 1, then all enables = 1; stall_cycles = 2.
- Timeout (MEM_TIMEOUT = 4): mem_ready never asserted → release after 4 cycles, mem_err = 1 and stays 1.
- Branch during a wait: ex_br_taken = 1 while SW waits 2 cycles → no flush until release, then fd_bubble = de_bubble = 1 on the release cycle.
- Branch plus load-use in the same cycle → flush only, pc_wrt_en = 1.
- Reset pulse during MEM_WAIT → outputs 0 immediately, counters 0; after release, mem_req reasserts for the pending LW.
